// File: rtl/io_input_conditioner.sv
// Board switch/key conditioner: two-flop synchroniser, shared-tick debounce,
// zero-extended read words for the LSU and one-cycle key press pulses.
module io_input_conditioner #(
  parameter int SW_WIDTH   = 18,
  parameter int BTN_WIDTH  = 4,
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  output logic [31:0]          o_ph_sw,
  output logic [31:0]          o_ph_button,
  output logic [BTN_WIDTH-1:0] o_btn_press,
  output logic                 o_tick
);

  localparam int NB = SW_WIDTH + BTN_WIDTH;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CNT - 1);
  // Keys are active-low, so their idle (released) level is 1.
  localparam logic [NB-1:0] IDLE = {{BTN_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};

  logic [NB-1:0]        raw;
  logic [NB-1:0]        meta;
  logic [NB-1:0]        sync;
  logic [NB-1:0]        stable;
  logic [PW-1:0]        presc;
  logic [PW-1:0]        presc_next;
  logic                 tick;
  logic [BTN_WIDTH-1:0] btn_stable;
  logic [BTN_WIDTH-1:0] btn_prev;

  assign raw = {i_btn_raw, i_sw_raw};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      meta <= IDLE;
      sync <= IDLE;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // tick is high for exactly the cycle in which presc holds its last value
  assign presc_next = (presc == PRESC_LAST) ? '0 : presc + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_next;
      tick  <= (presc_next == PRESC_LAST);
    end
  end

  generate
    for (genvar b = 0; b < NB; b++) begin : g_db
      logic [CW-1:0] cnt;
      logic          level;

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          cnt   <= '0;
          level <= IDLE[b];
        end else if (tick) begin
          if (sync[b] == level) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            level <= sync[b];
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign stable[b] = level;
    end
  endgenerate

  assign btn_stable = stable[NB-1:SW_WIDTH];

  // Press pulse fires the cycle after the debounced level falls.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      btn_prev    <= '1;
      o_btn_press <= '0;
    end else begin
      btn_prev    <= btn_stable;
      o_btn_press <= btn_prev & ~btn_stable;
    end
  end

  assign o_ph_sw     = 32'(stable[SW_WIDTH-1:0]);
  assign o_ph_button = 32'(btn_stable);
  assign o_tick      = tick;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench: dut_a (TICK_DIV=4, STABLE_CNT=3) and dut_b (TICK_DIV=1, STABLE_CNT=1).
module tb_io_input_conditioner;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [17:0] sw_a, sw_b;
  logic [3:0]  btn_a, btn_b;
  logic [31:0] ph_sw_a, ph_btn_a, ph_sw_b, ph_btn_b;
  logic [3:0]  press_a, press_b;
  logic        tick_a, tick_b;

  int checks = 0;
  int errors = 0;

  io_input_conditioner #(.SW_WIDTH(18), .BTN_WIDTH(4), .TICK_DIV(4), .STABLE_CNT(3)) dut_a (
    .i_clk(clk), .i_reset(rst_a), .i_sw_raw(sw_a), .i_btn_raw(btn_a),
    .o_ph_sw(ph_sw_a), .o_ph_button(ph_btn_a), .o_btn_press(press_a), .o_tick(tick_a));

  io_input_conditioner #(.SW_WIDTH(18), .BTN_WIDTH(4), .TICK_DIV(1), .STABLE_CNT(1)) dut_b (
    .i_clk(clk), .i_reset(rst_b), .i_sw_raw(sw_b), .i_btn_raw(btn_b),
    .o_ph_sw(ph_sw_b), .o_ph_button(ph_btn_b), .o_btn_press(press_b), .o_tick(tick_b));

  typedef struct {
    logic [17:0] sw;
    logic [3:0]  btn;
    logic [31:0] exp_sw;
    logic [31:0] exp_btn;
    logic [3:0]  exp_press;
  } vec_t;

  vec_t vecs[7];
  int   exp_lat[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at the falling edge right after reset release.
  task automatic reset_a();
    rst_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  // Counts edges from the current point until o_ph_sw reads want; checks exact latency.
  task automatic measure_sw(input string name, input logic [31:0] want, input int exp_k);
    int first;
    int pre_bad;
    int post_bad;
    first = -1; pre_bad = 0; post_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (first < 0 && ph_sw_a == want) first = k;
      else if (first < 0 && ph_sw_a != 32'h0) pre_bad++;
      else if (first >= 0 && ph_sw_a != want) post_bad++;
    end
    check({name, "_pre_zero"}, pre_bad, 0);
    check({name, "_edge"}, first, exp_k);
    check({name, "_hold"}, post_bad, 0);
  endtask

  initial begin
    vecs[0] = '{18'h00005, 4'hF, 32'h00000005, 32'h0000000F, 4'h0};
    vecs[1] = '{18'h3FFFF, 4'h6, 32'h0003FFFF, 32'h00000006, 4'h9};
    vecs[2] = '{18'h00000, 4'hF, 32'h00000000, 32'h0000000F, 4'h0};
    vecs[3] = '{18'h2AAAA, 4'h0, 32'h0002AAAA, 32'h00000000, 4'hF};
    vecs[4] = '{18'h15555, 4'h0, 32'h00015555, 32'h00000000, 4'h0};
    vecs[5] = '{18'h00000, 4'hE, 32'h00000000, 32'h0000000E, 4'h0};
    vecs[6] = '{18'h00F0F, 4'hD, 32'h00000F0F, 32'h0000000D, 4'h2};
    // Edges from raw change to o_ph_sw, for a change applied p edges after release.
    exp_lat[0] = 12; exp_lat[1] = 11; exp_lat[2] = 14; exp_lat[3] = 13;

    rst_b = 1'b0; sw_b = '0; btn_b = 4'hF;

    // Reset values with opposite raw levels held
    sw_a = 18'h3FFFF; btn_a = 4'h0;
    reset_a();
    #1;
    check("rst_sw", ph_sw_a, 32'h0);
    check("rst_btn", ph_btn_a, 32'h0000000F);
    check("rst_press", {28'h0, press_a}, 32'h0);
    check("rst_tick", {31'h0, tick_a}, 32'h0);
    sw_a = '0; btn_a = 4'hF;
    for (int r = 1; r <= 8; r++) begin
      step();
      check("tick_phase", {31'h0, tick_a}, (r % 4 == 3) ? 32'h1 : 32'h0);
    end

    // Latency at each prescaler phase
    for (int p = 0; p < 4; p++) begin
      sw_a = '0;
      reset_a();
      for (int i = 0; i < p; i++) step();
      sw_a = 18'h00005;
      measure_sw($sformatf("lat_p%0d", p), 32'h5, exp_lat[p]);
    end

    // Reset in the middle of a debounce discards the partial count
    sw_a = '0;
    reset_a();
    step();
    sw_a = 18'h00005;
    repeat (8) step();
    rst_a = 1'b0;
    #1;
    check("rstmid_async", ph_sw_a, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_held", ph_sw_a, 32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    measure_sw("rstmid_fresh", 32'h5, 12);

    // Table of settled levels and press pulses
    sw_a = '0; btn_a = 4'hF;
    reset_a();
    for (int v = 0; v < 7; v++) begin
      logic [3:0] press_or;
      int         pulses;
      press_or = '0; pulses = 0;
      sw_a = vecs[v].sw; btn_a = vecs[v].btn;
      for (int k = 0; k < 24; k++) begin
        step();
        press_or |= press_a;
        pulses   += $countones(press_a);
      end
      check($sformatf("vec%0d_sw", v), ph_sw_a, vecs[v].exp_sw);
      check($sformatf("vec%0d_btn", v), ph_btn_a, vecs[v].exp_btn);
      check($sformatf("vec%0d_press", v), {28'h0, press_or}, {28'h0, vecs[v].exp_press});
      check($sformatf("vec%0d_pulses", v), pulses, $countones(vecs[v].exp_press));
    end

    // Press pulse lands one cycle after the level, once
    sw_a = '0; btn_a = 4'hF;
    repeat (24) step();
    begin
      int chg, pk, pn;
      logic [3:0] pv;
      chg = -1; pk = -1; pn = 0; pv = '0;
      btn_a = 4'h6;
      for (int k = 1; k <= 24; k++) begin
        step();
        if (chg < 0 && ph_btn_a == 32'h6) chg = k;
        if (press_a != 4'h0) begin
          pn++;
          if (pk < 0) begin pk = k; pv = press_a; end
        end
      end
      check("press_lvl_window", (chg >= 11 && chg <= 14) ? 32'h1 : 32'h0, 32'h1);
      check("press_val", {28'h0, pv}, 32'h9);
      check("press_cycle", pk, chg + 1);
      check("press_once", pn, 1);
      pn = 0;
      btn_a = 4'hF;
      for (int k = 1; k <= 24; k++) begin
        step();
        if (press_a != 4'h0) pn++;
      end
      check("release_btn", ph_btn_a, 32'hF);
      check("release_nopulse", pn, 0);
    end

    // Short key glitch, then a switch pattern whose low gaps clear the count
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 36; k++) begin
        btn_a = (k < 6) ? 4'hB : 4'hF;
        step();
        if (ph_btn_a != 32'hF || press_a != 4'h0) bad++;
      end
      check("glitch_btn", bad, 0);
      bad = 0;
      for (int k = 0; k < 44; k++) begin
        sw_a = (k < 8 || (k >= 12 && k < 20)) ? 18'h00001 : 18'h00000;
        step();
        if (ph_sw_a != 32'h0) bad++;
      end
      check("glitch_sw_clear", bad, 0);
    end

    // dut_b: tick every cycle, 3-cycle path, immediate acceptance
    begin
      logic hist[64];
      @(negedge clk);
      rst_b = 1'b1;
      hist[0] = 1'b1;
      sw_b[0] = hist[0];
      for (int n = 1; n <= 30; n++) begin
        step();
        check("b_tick", {31'h0, tick_b}, 32'h1);
        check("b_follow", ph_sw_b, (n < 3) ? 32'h0 : {31'h0, hist[n-3]});
        hist[n] = ~hist[n-1];
        sw_b[0] = hist[n];
      end
      sw_b = '0;
      repeat (4) step();
      btn_b = 4'hD;
      for (int k = 1; k <= 6; k++) begin
        step();
        check("b_press_lvl", ph_btn_b, (k >= 3) ? 32'hD : 32'hF);
        check("b_press", {28'h0, press_b}, (k == 4) ? 32'h2 : 32'h0);
      end
      btn_b = 4'hF;
      for (int k = 1; k <= 6; k++) begin
        step();
        check("b_release_lvl", ph_btn_b, (k >= 3) ? 32'hF : 32'hD);
        check("b_release", {28'h0, press_b}, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Upstream neighbour of the load/store unit's switch and button read ports.
- Takes raw asynchronous board switch and key pins.
- Synchronises them into the core clock domain and debounces each bit with a shared sample tick.
- Produces the zero-extended 32-bit words the LSU returns on loads from the switch and button regions. Also produces one-cycle press pulses per key for future interrupt/event use.

Parameters:
- SW_WIDTH, 18: number of raw switch inputs (1..32).
- BTN_WIDTH, 4: number of raw key inputs (1..32); keys are active-low at the pin.
- TICK_DIV, 50000: core cycles per debounce sample tick (>=1).
- STABLE_CNT, 8: consecutive differing ticks required to accept a new level (>=1, <=255).

Ports:
- i_clk  input  1  core clock.
- i_reset  input  1  asynchronous, active-low reset.
- i_sw_raw  input  SW_WIDTH  raw switch pins, asynchronous.
- i_btn_raw  input  BTN_WIDTH  raw key pins, asynchronous, active-low (1 = released).
- o_ph_sw  output  32  debounced switches, zero-extended; feeds LSU i_ph_sw.
- o_ph_button  output  32  debounced key levels (active-low preserved), zero-extended; feeds LSU i_ph_button.
- o_btn_press  output  BTN_WIDTH  one-cycle pulse per key on debounced 1->0 (press).
- o_tick  output  1  debounce sample tick, for observability.

Behaviour:
- Reset: one clock; asynchronous, active-low reset on i_reset. All flops clear on reset.
  - Switch sync/stable bits reset to 0; key sync/stable bits reset to 1 (released).
  - Prescaler and all per-bit counters reset to 0.
  - Resulting outputs: o_ph_sw=0, o_ph_button={zeros,BTN_WIDTH ones}, o_btn_press=0, o_tick=0.
  - Reset asserted mid-debounce discards partial counts; there is no pending-change carryover.
- Synchroniser: two flops per bit on every clock; sync value = second stage.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - o_tick is registered high for exactly the cycle the counter equals TICK_DIV-1.
  - With TICK_DIV=1, o_tick is high every cycle after reset release.
- Per-bit debounce (identical for switch and key bits), evaluated only on tick cycles:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt == STABLE_CNT-1: stable <= sync, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - On non-tick cycles, cnt and stable hold.
- Latency: a clean raw change reaches o_ph_* between 3+(STABLE_CNT-1)*TICK_DIV and 2+STABLE_CNT*TICK_DIV rising edges after the change, depending on prescaler phase.
- Glitch rejection: any excursion shorter than STABLE_CNT consecutive ticks leaves stable unchanged. Returning to the stable level on any tick clears cnt.
- Outputs:
  - o_ph_sw = {(32-SW_WIDTH) zeros, stable_sw}.
  - o_ph_button = {(32-BTN_WIDTH) zeros, stable_btn}.
  - Both are registered; no combinational path from the raw pins.
- Press pulse:
  - o_btn_press[i] is registered high for one cycle, the cycle after stable_btn[i] goes 1->0.
  - Release (0->1) produces no pulse.
  - Simultaneous presses on several keys pulse the corresponding bits in the same cycle.
- Bits are fully independent; simultaneous changes on any mix of bits debounce in parallel.
- Counter width: ceil(log2(STABLE_CNT)) bits minimum, 1 bit when STABLE_CNT=1. Prescaler width: ceil(log2(TICK_DIV)), 1 bit minimum; no overflow past the wrap value.

Test Plan:
- Reset with i_sw_raw=18'h3FFFF, i_btn_raw=4'h0 held -> immediately after reset release: o_ph_sw=0, o_ph_button=32'h0000000F, o_btn_press=0.
- TICK_DIV=4, STABLE_CNT=3; release reset, then at edge 0 set i_sw_raw=18'h00005 and hold -> o_ph_sw=32'h00000005 no earlier than edge 11 and no later than edge 14; o_ph_sw=0 before that.
- Same parameters; i_btn_raw[2] driven 0 for 6 cycles then back to 1 -> o_ph_button stays 32'h0000000F; o_btn_press stays 0.
- Same parameters; i_btn_raw=4'b0110 held -> o_ph_button becomes 32'h00000006, and o_btn_press=4'b1001 for exactly one cycle after it. Then i_btn_raw=4'hF held -> o_ph_button=32'h0000000F with no press pulse.
- TICK_DIV=1, STABLE_CNT=1; toggle i_sw_raw[0] each cycle -> o_ph_sw[0] follows with exactly 3-cycle delay; o_tick constant 1.
- TICK_DIV=4, STABLE_CNT=3; start a switch change, assert i_reset low after 2 ticks, release it, keep the raw value held -> o_ph_sw reads 0 during and after reset, then changes only after a full fresh 11-14-edge window.
